// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - signed 8-bit radix-2 restoring sequential divider
//
// Purpose : divides two signed 8-bit operands by restoring division on their
//           magnitudes (one quotient bit per clock, MSB first), then applies the
//           sign fix. Quotient truncates toward zero and the remainder takes the
//           sign of the dividend.
// Ports   : clk         - rising-edge clock
//           rst         - asynchronous active-high reset
//           start       - request a division (ignored while busy)
//           dividend    - signed numerator, sampled on the capture edge only
//           divisor     - signed denominator, sampled on the capture edge only
//           busy        - high in RUN and FIX
//           done        - one-cycle result-valid pulse
//           quotient    - registered signed quotient
//           remainder   - registered signed remainder
//           div_by_zero - only with DIV_ZERO_DETECT_EN: high in the done cycle
//                         of a divide by zero
// Config  : DIV_ZERO_DETECT_EN - when defined, a zero divisor skips the
//           iterations and finishes on the capture edge with q=8'hFF,
//           r=dividend. When undefined, a zero divisor runs the normal sequence.

module seq_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder
`ifdef DIV_ZERO_DETECT_EN
  ,
  output logic       div_by_zero
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt;
  logic [8:0] prem;      // partial remainder
  logic [7:0] qsh;       // dividend magnitude shifting out, quotient bits shifting in
  logic [7:0] dvs;       // divisor magnitude
  logic       neg_q;
  logic       neg_r;

  logic       capture;
  logic       zero_div;
  logic [8:0] shifted;
  logic [9:0] diff;
  logic       fits;

  function automatic logic [7:0] mag(input logic [7:0] v);
    return v[7] ? (~v + 8'd1) : v;
  endfunction

  assign capture = start && (state == IDLE || state == DONE);

`ifdef DIV_ZERO_DETECT_EN
  assign zero_div = (divisor == 8'h00);
`else
  assign zero_div = 1'b0;
`endif

  // Trial subtraction. A set bit shifted out of prem[8] means the shifted value
  // certainly exceeds the divisor, so it also counts as a fit.
  assign shifted = {prem[7:0], qsh[7]};
  assign diff    = {1'b0, shifted} - {2'b00, dvs};
  assign fits    = prem[8] | ~diff[9];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (capture) state_nxt = zero_div ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == 3'd7) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (capture) state_nxt = zero_div ? DONE : RUN;
        else         state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 3'd0;
      prem      <= 9'd0;
      qsh       <= 8'd0;
      dvs       <= 8'd0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= 8'h00;
      remainder <= 8'h00;
    end else if (capture) begin
      cnt   <= 3'd0;
      prem  <= 9'd0;
      qsh   <= mag(dividend);
      dvs   <= mag(divisor);
      neg_q <= dividend[7] ^ divisor[7];
      neg_r <= dividend[7];
      if (zero_div) begin
        quotient  <= 8'hFF;
        remainder <= dividend;
      end
    end else if (state == RUN) begin
      prem <= fits ? diff[8:0] : shifted;
      qsh  <= {qsh[6:0], fits};
      cnt  <= cnt + 3'd1;
    end else if (state == FIX) begin
      quotient  <= neg_q ? (~qsh + 8'd1) : qsh;
      remainder <= neg_r ? (~prem[7:0] + 8'd1) : prem[7:0];
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  // Only the cycle after a zero-divisor capture is a done cycle for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_by_zero <= 1'b0;
    end else begin
      div_by_zero <= capture && zero_div;
    end
  end
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider

module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
  logic       div_by_zero;
`endif

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } res_t;

  res_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  seq_divider dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_ZERO_DETECT_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result from the language's own signed division.
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
    res_t m;
    int   ia, ib, iq, ir;
    ia   = int'($signed(a));
    ib   = int'($signed(b));
    m.dz = 1'b0;
    if (ib == 0) begin
`ifdef DIV_ZERO_DETECT_EN
      iq   = 255;
      ir   = ia;
      m.dz = 1'b1;
`else
      iq = (ia < 0) ? -255 : 255;
      ir = ia;
`endif
    end else begin
      iq = ia / ib;
      ir = ia % ib;
    end
    m.q = iq[7:0];
    m.r = ir[7:0];
    return m;
  endfunction

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b));
  endtask

  // Called at the negedge where start was raised; returns at the done negedge.
  task automatic finish_div(input string tag, input int exp_lat, input int inject_at);
    int   cycles   = 0;
    int   busy_cnt = 0;
    bit   seen     = 1'b0;
    res_t e;
    while (cycles < 40 && !seen) begin
      @(negedge clk);
      cycles++;
      if (cycles == inject_at) begin
        start    = 1'b1;
        dividend = 8'd90;
        divisor  = 8'd9;
      end else begin
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
      end
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
    end
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, ".latency"}, cycles, exp_lat);
      check({tag, ".busy_cycles"}, busy_cnt, exp_lat - 1);
      check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
      check({tag, ".sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, ".q"}, 32'(quotient), 32'(e.q));
        check({tag, ".r"}, 32'(remainder), 32'(e.r));
`ifdef DIV_ZERO_DETECT_EN
        check({tag, ".dz"}, 32'(div_by_zero), 32'(e.dz));
`endif
      end
    end
  endtask

  logic [7:0] a_tab [8] = '{8'd100, 8'h9C, 8'd100, 8'h9C, 8'h80, 8'h80, 8'd7,   8'd127};
  logic [7:0] b_tab [8] = '{8'd7,   8'd7,  8'hF9,  8'hF9, 8'hFF, 8'd1,  8'd100, 8'h80};

  initial begin
    int done_cnt;
    int zlat;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (2) @(negedge clk);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.q", 32'(quotient), 32'd0);
    check("reset.r", 32'(remainder), 32'd0);
`ifdef DIV_ZERO_DETECT_EN
    check("reset.dz", 32'(div_by_zero), 32'd0);
`endif
    rst = 1'b0;

    // Directed sign and boundary cases.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      launch(a_tab[i], b_tab[i]);
      finish_div($sformatf("div%0d", i), 10, 0);
      @(negedge clk);
      check($sformatf("div%0d.pulse_end", i), 32'(done), 32'd0);
    end

    // Start during RUN cycle 3 is ignored; start held at DONE runs back to back.
    @(negedge clk);
    launch(8'd40, 8'd3);
    finish_div("ignore", 10, 3);
    launch(8'd90, 8'd9);
    finish_div("b2b", 10, 0);
    @(negedge clk);
    check("b2b.pulse_end", 32'(done), 32'd0);

    // Reset in RUN cycle 5 aborts with no done pulse.
    @(negedge clk);
    launch(8'd50, 8'd7);
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort.q_hold", 32'(quotient), 32'd10);
    check("abort.busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.q", 32'(quotient), 32'd0);
    check("abort.r", 32'(remainder), 32'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst      = 1'b0;
    done_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort.no_done", done_cnt, 0);
    @(negedge clk);
    launch(8'd50, 8'd5);
    finish_div("after_abort", 10, 0);

    // Divide by zero.
`ifdef DIV_ZERO_DETECT_EN
    zlat = 1;
`else
    zlat = 10;
`endif
    @(negedge clk);
    launch(8'd5, 8'd0);
    finish_div("dz_pos", zlat, 0);
    @(negedge clk);
    check("dz_pos.pulse_end", 32'(done), 32'd0);
`ifdef DIV_ZERO_DETECT_EN
    check("dz_pos.flag_clear", 32'(div_by_zero), 32'd0);
`endif
    @(negedge clk);
    launch(8'hFB, 8'd0);
    finish_div("dz_neg", zlat, 0);

    check("sb.drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
